// File: rtl/dmem_responder.sv
// Data-memory responder: single-outstanding load/store with programmable wait states,
// byte/half/word lane steering, sign/zero extension and alignment error reporting.
`timescale 1ns/1ps
module dmem_responder #(
   parameter int AW_WORDS = 7,
   parameter int WAIT_CYC = 2
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_wr,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [2:0]  req_type,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_err
);

   localparam int ABITS = AW_WORDS + 2;
   localparam int DEPTH = 1 << AW_WORDS;
   localparam logic [3:0] CNT_INIT = (WAIT_CYC > 0) ? 4'(WAIT_CYC - 1) : 4'd0;

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

   state_e            state_q;
   logic [3:0]        cnt_q;
   logic              wr_q;
   logic [ABITS-1:0]  addr_q;
   logic [31:0]       wdata_q;
   logic [2:0]        type_q;
   logic              valid_q;
   logic              err_q;
   logic [31:0]       rdata_q;
   logic [31:0]       mem_q [DEPTH];

   logic              accept;
   logic              enter_resp;
   logic              cur_wr;
   logic [ABITS-1:0]  cur_addr;
   logic [31:0]       cur_wdata;
   logic [2:0]        cur_type;
   logic [AW_WORDS-1:0] idx;
   logic [1:0]        lo;
   logic [31:0]       rword;
   logic [15:0]       half;
   logic [7:0]        byt;
   logic [3:0]        be;
   logic [31:0]       wlane;
   logic [31:0]       ldata;
   logic              err_c;
   logic              unused_addr;

   assign unused_addr = ^req_addr[31:ABITS];

   assign req_ready  = (state_q == IDLE) && rstn;
   assign accept     = req_valid && req_ready;
   assign enter_resp = (accept && (WAIT_CYC == 0)) || ((state_q == WAIT) && (cnt_q == 4'd0));

   // With no wait states the response is produced on the accept edge itself,
   // so decode must look at the live request rather than the latched copy.
   always_comb begin
      cur_wr    = wr_q;
      cur_addr  = addr_q;
      cur_wdata = wdata_q;
      cur_type  = type_q;
      if (state_q == IDLE) begin
         cur_wr    = req_wr;
         cur_addr  = req_addr[ABITS-1:0];
         cur_wdata = req_wdata;
         cur_type  = req_type;
      end
   end

   assign idx   = cur_addr[ABITS-1:2];
   assign lo    = cur_addr[1:0];
   assign rword = mem_q[idx];

   always_comb begin
      err_c = 1'b0;
      be    = 4'h0;
      wlane = 32'h0;
      ldata = 32'h0;
      half  = lo[1] ? rword[31:16] : rword[15:0];
      byt   = 8'(rword >> {lo, 3'b000});
      case (cur_type)
         3'd0: begin
            err_c = (lo != 2'b00);
            be    = 4'hF;
            wlane = cur_wdata;
            ldata = rword;
         end
         3'd1, 3'd2: begin
            err_c = lo[0];
            be    = lo[1] ? 4'b1100 : 4'b0011;
            wlane = {2{cur_wdata[15:0]}};
            ldata = (cur_type == 3'd1) ? {{16{half[15]}}, half} : {16'h0, half};
         end
         3'd3, 3'd4: begin
            be    = 4'b0001 << lo;
            wlane = {4{cur_wdata[7:0]}};
            ldata = (cur_type == 3'd3) ? {{24{byt[7]}}, byt} : {24'h0, byt};
         end
         default: err_c = 1'b1;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= IDLE;
         cnt_q   <= 4'd0;
         wr_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= 32'h0;
         type_q  <= 3'd0;
         valid_q <= 1'b0;
         err_q   <= 1'b0;
         rdata_q <= 32'h0;
      end else begin
         valid_q <= 1'b0;
         err_q   <= 1'b0;
         rdata_q <= 32'h0;
         case (state_q)
            IDLE: begin
               if (accept) begin
                  wr_q    <= req_wr;
                  addr_q  <= req_addr[ABITS-1:0];
                  wdata_q <= req_wdata;
                  type_q  <= req_type;
                  if (WAIT_CYC == 0) begin
                     state_q <= RESP;
                  end else begin
                     state_q <= WAIT;
                     cnt_q   <= CNT_INIT;
                  end
               end
            end
            WAIT: begin
               if (cnt_q == 4'd0) state_q <= RESP;
               else               cnt_q   <= cnt_q - 4'd1;
            end
            RESP:    state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
         if (enter_resp) begin
            valid_q <= 1'b1;
            err_q   <= err_c;
            rdata_q <= (cur_wr || err_c) ? 32'h0 : ldata;
         end
      end
   end

   // Contents survive reset; an aborted store never reaches enter_resp.
   always_ff @(posedge clk) begin
      if (enter_resp && cur_wr && !err_c) begin
         for (int i = 0; i < 4; i++) begin
            if (be[i]) mem_q[idx][8*i +: 8] <= wlane[8*i +: 8];
         end
      end
   end

   assign resp_valid = valid_q;
   assign resp_rdata = rdata_q;
   assign resp_err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized bench for dmem_responder: two instances (2 and 0 wait states) checked
// against a byte-array memory model with size/alignment rules.
`timescale 1ns/1ps
module tb_dmem_responder;

   logic        clk;
   logic        rstn [2];
   logic        rv   [2];
   logic        rdy  [2];
   logic        rw   [2];
   logic [31:0] ra   [2];
   logic [31:0] rwd  [2];
   logic [2:0]  rt   [2];
   logic        vld  [2];
   logic [31:0] rdat [2];
   logic        err  [2];

   logic [7:0]  mb [2][512];
   int          checks = 0;
   int          errors = 0;

   dmem_responder #(.AW_WORDS(7), .WAIT_CYC(2)) u_dut0 (
      .clk(clk), .rstn(rstn[0]), .req_valid(rv[0]), .req_ready(rdy[0]), .req_wr(rw[0]),
      .req_addr(ra[0]), .req_wdata(rwd[0]), .req_type(rt[0]), .resp_valid(vld[0]),
      .resp_rdata(rdat[0]), .resp_err(err[0]));

   dmem_responder #(.AW_WORDS(7), .WAIT_CYC(0)) u_dut1 (
      .clk(clk), .rstn(rstn[1]), .req_valid(rv[1]), .req_ready(rdy[1]), .req_wr(rw[1]),
      .req_addr(ra[1]), .req_wdata(rwd[1]), .req_type(rt[1]), .resp_valid(vld[1]),
      .resp_rdata(rdat[1]), .resp_err(err[1]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int wc_of(input int d);
      return (d == 0) ? 2 : 0;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", tag, obs, exp);
      end
   endtask

   // Memory as bytes, little-endian; accesses of size 1/2/4 must be naturally aligned.
   task automatic model(input int d, input logic wr, input logic [31:0] a, input logic [31:0] wd,
                        input logic [2:0] t, output logic [31:0] rd, output logic er);
      int sz;
      int b;
      logic [31:0] v;
      case (t)
         3'd0:       sz = 4;
         3'd1, 3'd2: sz = 2;
         3'd3, 3'd4: sz = 1;
         default:    sz = 0;
      endcase
      if (sz == 0) er = 1'b1;
      else         er = (int'(a[1:0]) % sz) != 0;
      rd = 32'h0;
      b  = int'(a[8:0]);
      if (!er) begin
         if (wr) begin
            for (int i = 0; i < sz; i++) mb[d][b+i] = wd[8*i +: 8];
         end else begin
            v = 32'h0;
            for (int i = 0; i < sz; i++) v = v | (32'(mb[d][b+i]) << (8*i));
            if ((t == 3'd1 || t == 3'd3) && v[8*sz-1]) v = v | ~((32'd1 << (8*sz)) - 32'd1);
            rd = v;
         end
      end
   endtask

   task automatic acc(input int d, input logic wr, input logic [31:0] a, input logic [31:0] wd,
                      input logic [2:0] t, output logic [31:0] rd);
      logic [31:0] er;
      logic        ee;
      int          k;
      model(d, wr, a, wd, t, er, ee);
      k = 0;
      while (!rdy[d] && k < 50) begin
         @(posedge clk); #1;
         k++;
      end
      check("ready", 32'(rdy[d]), 32'd1);
      rv[d] = 1'b1; rw[d] = wr; ra[d] = a; rwd[d] = wd; rt[d] = t;
      @(posedge clk); #1;
      rv[d] = 1'b0; rw[d] = 1'($urandom); ra[d] = $urandom; rwd[d] = $urandom; rt[d] = 3'($urandom);
      k = 1;
      while (!vld[d] && k < 40) begin
         @(posedge clk); #1;
         k++;
      end
      check("latency", 32'(k), 32'(wc_of(d) + 1));
      check("rdata", rdat[d], er);
      check("err", 32'(err[d]), 32'(ee));
      rd = rdat[d];
      @(posedge clk); #1;
      check("vld_drop", 32'(vld[d]), 32'd0);
      check("rdata_idle", rdat[d], 32'd0);
   endtask

   initial begin
      logic [31:0] rd;
      logic [31:0] prior;
      logic [31:0] er;
      logic        ee;
      logic [31:0] a;
      logic [2:0]  t;
      for (int d = 0; d < 2; d++) begin
         rstn[d] = 1'b0; rv[d] = 1'b0; rw[d] = 1'b0; ra[d] = 32'h0; rwd[d] = 32'h0; rt[d] = 3'd0;
      end
      #23;
      for (int d = 0; d < 2; d++) begin
         check("rst_ready", 32'(rdy[d]), 32'd0);
         check("rst_valid", 32'(vld[d]), 32'd0);
         check("rst_rdata", rdat[d], 32'd0);
         check("rst_err", 32'(err[d]), 32'd0);
      end
      @(negedge clk);
      rstn[0] = 1'b1; rstn[1] = 1'b1;
      #1;
      check("ready_after_rst0", 32'(rdy[0]), 32'd1);
      check("ready_after_rst1", 32'(rdy[1]), 32'd1);

      for (int d = 0; d < 2; d++)
         for (int w = 0; w < 32; w++) acc(d, 1'b1, 32'(w * 4), $urandom, 3'd0, rd);

      acc(0, 1'b1, 32'h10, 32'h11223344, 3'd0, rd);
      acc(0, 1'b0, 32'h10, 32'h0, 3'd0, rd);            check("w_load", rd, 32'h11223344);
      acc(0, 1'b0, 32'h13, 32'h0, 3'd3, rd);            check("lb_13", rd, 32'h00000011);
      acc(0, 1'b1, 32'h12, 32'hABCDEF80, 3'd4, rd);
      acc(0, 1'b0, 32'h12, 32'h0, 3'd3, rd);            check("lb_12", rd, 32'hFFFFFF80);
      acc(0, 1'b0, 32'h12, 32'h0, 3'd4, rd);            check("lbu_12", rd, 32'h00000080);
      acc(0, 1'b0, 32'h10, 32'h0, 3'd0, rd);            check("lw_after_sb", rd, 32'h11803344);

      acc(0, 1'b0, 32'h20, 32'h0, 3'd0, prior);
      acc(0, 1'b1, 32'h22, 32'h1234BEEF, 3'd2, rd);
      acc(0, 1'b0, 32'h22, 32'h0, 3'd1, rd);            check("lh_22", rd, 32'hFFFFBEEF);
      acc(0, 1'b0, 32'h20, 32'h0, 3'd0, rd);
      check("lw20_hi", 32'(rd[31:16]), 32'h0000BEEF);
      check("lw20_lo", 32'(rd[15:0]), 32'(prior[15:0]));

      acc(0, 1'b0, 32'h06, 32'h0, 3'd0, rd);
      acc(0, 1'b0, 32'h05, 32'h0, 3'd1, rd);
      acc(0, 1'b0, 32'h10, 32'h0, 3'd7, rd);
      acc(0, 1'b1, 32'h12, 32'hFFFFFFFF, 3'd0, rd);
      acc(0, 1'b1, 32'h11, 32'hFFFFFFFF, 3'd2, rd);
      acc(0, 1'b1, 32'h10, 32'hFFFFFFFF, 3'd6, rd);
      acc(0, 1'b0, 32'h10, 32'h0, 3'd0, rd);            check("no_write_on_err", rd, 32'h11803344);

      for (int n = 0; n < 300; n++) begin
         a = $urandom & 32'hFFFF_FE3F;
         t = ($urandom_range(0, 9) < 8) ? 3'($urandom_range(0, 4)) : 3'($urandom_range(5, 7));
         acc(n % 2, 1'($urandom_range(0, 1)), a, $urandom, t, rd);
      end

      // Reset in the middle of the wait states of a store.
      model(0, 1'b0, 32'h40, 32'h0, 3'd0, er, ee);
      rv[0] = 1'b1; rw[0] = 1'b1; ra[0] = 32'h40; rwd[0] = 32'hDEADBEEF; rt[0] = 3'd0;
      @(posedge clk); #1;
      rv[0] = 1'b0;
      @(posedge clk); #1;
      rstn[0] = 1'b0;
      #1;
      check("abort_ready", 32'(rdy[0]), 32'd0);
      check("abort_valid", 32'(vld[0]), 32'd0);
      check("abort_rdata", rdat[0], 32'd0);
      check("abort_err", 32'(err[0]), 32'd0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      check("abort_valid_hold", 32'(vld[0]), 32'd0);
      @(negedge clk);
      rstn[0] = 1'b1;
      #1;
      check("abort_ready_rel", 32'(rdy[0]), 32'd1);
      acc(0, 1'b0, 32'h40, 32'h0, 3'd0, rd);            check("abort_mem", rd, er);

      // Continuous requests with no wait states, aliased address.
      acc(1, 1'b1, 32'h000, 32'hCAFEF00D, 3'd0, rd);
      acc(1, 1'b0, 32'h200, 32'h0, 3'd0, rd);           check("alias_200", rd, 32'hCAFEF00D);
      model(1, 1'b0, 32'h200, 32'h0, 3'd0, er, ee);
      rv[1] = 1'b1; rw[1] = 1'b0; ra[1] = 32'h200; rt[1] = 3'd0;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #1;
         check("burst_ready", 32'(rdy[1]), 32'(i % 2));
         check("burst_valid", 32'(vld[1]), 32'(i % 2 == 0));
         check("burst_rdata", rdat[1], (i % 2 == 0) ? er : 32'h0);
      end
      rv[1] = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL timeout got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
